mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory access sequencer for the LC-3 datapath, directly downstream of the effective-address adder. Latches the 16-bit effective address as MAR and runs the LD, ST, LDI and STI memory transactions over a req/ack memory port. Indirect operations first fetch a pointer, then access the pointed-to word. Returns load data and a one-cycle completion or error pulse to the control unit.

## Interface

Parameters:
- `TIMEOUT`, default 255: maximum cycles a request may wait for `mem_ack` before aborting. Range 1..65535.

Ports:
- `clk`, in, 1: single clock; all state is updated on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a transaction; sampled only in IDLE.
- `op`, in, 2: operation (`mem_op_t`), sampled with `start`.
- `ea`, in, 16: effective address from the address adder, sampled with `start`.
- `st_data`, in, 16: store data, sampled with `start`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a transaction finishes successfully.
- `err`, out, 1: one-cycle pulse when a transaction aborts on timeout.
- `ld_data`, out, 16: MDR; load result, valid from `done` until the next load completes.
- `mem_req`, out, 1: memory request.
- `mem_we`, out, 1: write enable; qualified by `mem_req`.
- `mem_addr`, out, 16: MAR.
- `mem_wdata`, out, 16: write data.
- `mem_ack`, in, 1: memory acknowledge.
- `mem_rdata`, in, 16: read data; valid in the cycle `mem_ack` is high.

## Operation

- **States**
  - IDLE
  - PTR: indirect pointer read
  - ACC: final read or write
  - DONE
  - ERR
- **IDLE**
  - On `start`, latch `ea` into MAR and `st_data` into the write-data register.
  - LDI and STI go to PTR; LD and ST go to ACC.
- **PTR**
  - Drive `mem_req=1`, `mem_we=0`.
  - On `mem_ack`: MAR ← `mem_rdata`, then go to ACC.
- **ACC**
  - Drive `mem_req=1`; `mem_we=1` for ST and STI.
  - On `mem_ack`:
    - For loads, MDR ← `mem_rdata`.
    - Go to DONE.
- **DONE**: `done=1` for one cycle, then IDLE.
- **ERR**: `err=1` for one cycle, then IDLE. MDR keeps its previous value.
- **Handshake**
  - A transfer occurs on the edge where `mem_req && mem_ack`.
  - `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req` is high.
  - `mem_req` is low in the cycle after each ack; there are no back-to-back requests.
- **Timeout**
  - The wait counter clears on entry to PTR or ACC and increments each cycle without ack.
  - When the counter reaches `TIMEOUT` with no ack, go to ERR. The timeout applies independently to each phase.
- **Boundaries**
  - `start` while `busy` is ignored.
  - `mem_ack` while `mem_req` is low is ignored.
  - Address 0xFFFF is legal; there is no increment and no wrap logic.
  - A pointer value of 0x0000 is legal.
- **Reset**
  - Reset at any time, including mid-transaction, returns to IDLE within the same cycle.
  - Reset values: `mem_req=0`, `mem_we=0`, `busy=0`, `done=0`, `err=0`, `mem_addr=0`, `mem_wdata=0`, `ld_data=0`, counter=0.

## Timing

- All outputs are registered or decoded from the state register; there are no combinational paths from input to output.
- With `start` sampled at edge 0:
  - LD/ST with immediate ack: `mem_req` high in cycle 1, `done` in cycle 2, back in IDLE in cycle 3.
  - LDI/STI with immediate acks: PTR in cycle 1, ACC in cycle 2, `done` in cycle 3.
- Each cycle of ack wait adds one cycle to the latency.
- Timeout: `err` is asserted `TIMEOUT`+1 cycles after phase entry when `mem_ack` stays low.
- The next `start` is accepted in the first IDLE cycle after `done` or `err`.

## Structure

- `lc3_pkg` holds:
  - `mem_op_t`: MEM_LD=2'b00, MEM_ST=2'b01, MEM_LDI=2'b10, MEM_STI=2'b11.
  - `mau_state_t`: the five states above.
  - `LC3_WORD_W=16`.
- Sub-module `mem_wait_timer`:
  - Parameterised `TIMEOUT`.
  - Inputs: `clr`, `en`. Output: `expired`.
  - Same clock and reset as the parent; instantiated once.

## Test plan

- **LD**: `ea`=0x3010, memory returns 0xBEEF with 0 wait → `mem_addr`=0x3010, `mem_we`=0, `ld_data`=0xBEEF, `done` in cycle 2.
- **ST**: `ea`=0xFFFF, `st_data`=0x1234, ack after 3 waits → write of 0x1234 to 0xFFFF, addr/data stable for 4 req cycles, `done` in cycle 5.
- **LDI**: `ea`=0x4000, mem[0x4000]=0x5000, mem[0x5000]=0x00AA → two reads at 0x4000 then 0x5000, `ld_data`=0x00AA, `done` in cycle 3.
- **STI timeout**: `TIMEOUT`=4, pointer read acked, final write never acked → `err` pulse, no `done`, `ld_data` unchanged, back in IDLE.
- **Busy and spurious inputs**: `start` pulsed during ACC, plus `mem_ack` pulsed in IDLE → both ignored, exactly one transaction completes.
- **Reset mid-transaction**: `rst_n` low during PTR wait → `mem_req`=0 and `busy`=0 immediately, all outputs at reset values, next LD completes normally.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types for the LC-3 memory access path.
//   mem_op_t    : memory operation requested by the control unit
//   mau_state_t : sequencer states of mem_access_unit
//   LC3_WORD_W  : datapath word width
package lc3_pkg;

  localparam int LC3_WORD_W = 16;

  typedef enum logic [1:0] {
    MEM_LD  = 2'b00,
    MEM_ST  = 2'b01,
    MEM_LDI = 2'b10,
    MEM_STI = 2'b11
  } mem_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PTR,
    ST_ACC,
    ST_DONE,
    ST_ERR
  } mau_state_t;

  // Indirect ops fetch a pointer first; store ops write in the final phase.
  function automatic logic is_indirect(input mem_op_t op);
    return (op == MEM_LDI) || (op == MEM_STI);
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_ST) || (op == MEM_STI);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting for a memory acknowledge.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return the count to zero (takes priority over en)
//   en         : count one more waited cycle
//   expired    : count has reached TIMEOUT
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LIMIT)) begin
      // Saturate so a stalled parent can never wrap the count back to zero.
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: LC-3 memory access sequencer for LD, ST, LDI and STI.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, op, ea,
//   st_data           : transaction request, sampled only while idle
//   busy, done, err   : status; done/err are one-cycle pulses
//   ld_data           : MDR, holds the most recent load result
//   mem_req, mem_we,
//   mem_addr,
//   mem_wdata         : memory request port (addr/wdata/we stable under req)
//   mem_ack, mem_rdata: memory response; rdata valid with ack
module mem_access_unit
  import lc3_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  mem_op_t               op,
  input  logic [LC3_WORD_W-1:0] ea,
  input  logic [LC3_WORD_W-1:0] st_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LC3_WORD_W-1:0] ld_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [LC3_WORD_W-1:0] mem_addr,
  output logic [LC3_WORD_W-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [LC3_WORD_W-1:0] mem_rdata
);

  mau_state_t            state_q;
  mem_op_t               op_q;
  logic [LC3_WORD_W-1:0] mar_q;
  logic [LC3_WORD_W-1:0] mdr_q;
  logic [LC3_WORD_W-1:0] wdata_q;

  logic in_phase;
  logic expired;

  assign in_phase = (state_q == ST_PTR) || (state_q == ST_ACC);

  // The count restarts whenever no phase is active or a phase completes,
  // so every PTR/ACC phase is entered with a fresh budget.
  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_phase || mem_ack),
    .en      (in_phase && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= MEM_LD;
      mar_q   <= '0;
      mdr_q   <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            mar_q   <= ea;
            wdata_q <= st_data;
            op_q    <= op;
            state_q <= is_indirect(op) ? ST_PTR : ST_ACC;
          end
        end
        ST_PTR: begin
          if (mem_ack) begin
            mar_q   <= mem_rdata;  // pointer becomes the final address
            state_q <= ST_ACC;
          end else if (expired) begin
            state_q <= ST_ERR;
          end
        end
        ST_ACC: begin
          if (mem_ack) begin
            if (!is_store(op_q)) begin
              mdr_q <= mem_rdata;
            end
            state_q <= ST_DONE;
          end else if (expired) begin
            state_q <= ST_ERR;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Status and request strobes decode straight from the state register.
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);
  assign mem_req   = in_phase;
  assign mem_we    = (state_q == ST_ACC) && is_store(op_q);
  assign mem_addr  = mar_q;
  assign mem_wdata = wdata_q;
  assign ld_data   = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import lc3_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  mem_op_t     op = MEM_LD;
  logic [15:0] ea = '0;
  logic [15:0] st_data = '0;
  logic        busy, done, err, mem_req, mem_we, mem_ack;
  logic [15:0] ld_data, mem_addr, mem_wdata, mem_rdata;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .ea(ea),
    .st_data(st_data), .busy(busy), .done(done), .err(err),
    .ld_data(ld_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  // ---------------- memory and responder ----------------
  logic [15:0] mem [logic [15:0]];
  int  resp_w [2];       // wait cycles per phase, -1 = never ack
  logic force_ack = 1'b0;

  function automatic logic [15:0] memrd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  initial begin
    int ph;
    int cnt;
    ph = 0;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        ph = 0;
        cnt = 0;
        mem_ack = force_ack;
        mem_rdata = force_ack ? 16'hDEAD : 16'h0000;
      end else if (resp_w[ph] >= 0 && cnt == resp_w[ph]) begin
        mem_ack = 1'b1;
        mem_rdata = memrd(mem_addr);
        if (mem_we) mem[mem_addr] = mem_wdata;
        cnt = 0;
        ph = (ph == 0) ? 1 : 0;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        cnt++;
      end
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        busy, req, we, done, err;
    logic [15:0] addr, wdata, ld;
  } rec_t;

  rec_t exp_q[$];
  logic [15:0] m_addr = '0, m_wd = '0, m_mdr = '0;

  function automatic rec_t mk(input logic b, r, w, d, e);
    rec_t x;
    x.busy = b; x.req = r; x.we = w; x.done = d; x.err = e;
    x.addr = m_addr; x.wdata = m_wd; x.ld = m_mdr;
    return x;
  endfunction

  // Expected cycle-by-cycle outputs of one transaction, starting at the
  // cycle in which start is presented.  Each phase lasts wait+1 cycles,
  // or TO+1 cycles if the ack never arrives in time.
  task automatic plan(input mem_op_t o, input logic [15:0] a,
                      input logic [15:0] wd, input int w0, input int w1);
    int nph, w, ncyc;
    logic last;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    m_addr = a;
    m_wd = wd;
    nph = (o == MEM_LDI || o == MEM_STI) ? 2 : 1;
    for (int p = 0; p < nph; p++) begin
      w = (p == 0) ? w0 : w1;
      last = (p == nph - 1);
      ncyc = (w < 0 || w > TO) ? TO + 1 : w + 1;
      for (int c = 0; c < ncyc; c++)
        exp_q.push_back(mk(1, 1, last && (o == MEM_ST || o == MEM_STI), 0, 0));
      if (w < 0 || w > TO) begin
        exp_q.push_back(mk(1, 0, 0, 0, 1));
        return;
      end
      if (!last) m_addr = memrd(m_addr);
      else if (o == MEM_LD || o == MEM_LDI) m_mdr = memrd(m_addr);
    end
    exp_q.push_back(mk(1, 0, 0, 1, 0));
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    rec_t e;
    logic [52:0] got, want;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(0, 0, 0, 0, 0);
      got  = {busy, mem_req, mem_we, done, err, mem_addr, mem_wdata, ld_data};
      want = {e.busy, e.req, e.we, e.done, e.err, e.addr, e.wdata, e.ld};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t: got busy/req/we/done/err/addr/wdata/ld=%h required %h",
                 $time, got, want);
      end
      if (done) n_done++;
    end
  end

  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] x);
    n_cmp++;
    if (g !== x) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, g, x);
    end else begin
      $display("ok   %s = %0h", name, g);
    end
  endtask

  // Drive one transaction; returns the cycle (after the start edge) of the
  // done/err pulse, or -1 if none appeared within the budget.
  task automatic run_txn(input mem_op_t o, input logic [15:0] a,
                         input logic [15:0] wd, input int w0, input int w1,
                         input int pulse_cyc, output int end_cyc,
                         output logic was_err);
    @(posedge clk); #1;
    start = 1'b1; op = o; ea = a; st_data = wd;
    resp_w[0] = w0; resp_w[1] = w1;
    plan(o, a, wd, w0, w1);
    @(posedge clk); #1;
    start = 1'b0;
    end_cyc = -1;
    was_err = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == pulse_cyc);
      if (c == pulse_cyc) begin
        op = MEM_STI; ea = 16'h1111; st_data = 16'h2222;
      end
      if (done || err) begin
        end_cyc = c;
        was_err = err;
        break;
      end
    end
    start = 1'b0;
    $display("txn op=%0d ea=%h wd=%h -> end cycle %0d err=%0b ld=%h",
             o, a, wd, end_cyc, was_err, ld_data);
  endtask

  initial begin
    int ec, d0;
    logic er;
    mem[16'h3010] = 16'hBEEF;
    mem[16'h4000] = 16'h5000;
    mem[16'h5000] = 16'h00AA;
    mem[16'h6000] = 16'h0000;
    mem[16'h0123] = 16'h7777;
    resp_w[0] = 0; resp_w[1] = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ld_data", {16'd0, ld_data}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // LD, zero wait
    run_txn(MEM_LD, 16'h3010, 16'h0000, 0, 0, 0, ec, er);
    chk("ld_done_cycle", ec, 2);
    chk("ld_data", {16'd0, ld_data}, 32'hBEEF);

    // ST to 0xFFFF, three wait cycles
    run_txn(MEM_ST, 16'hFFFF, 16'h1234, 3, 0, 0, ec, er);
    chk("st_done_cycle", ec, 5);
    chk("st_mem_written", {16'd0, memrd(16'hFFFF)}, 32'h1234);

    // LDI through pointer
    run_txn(MEM_LDI, 16'h4000, 16'h0000, 0, 0, 0, ec, er);
    chk("ldi_done_cycle", ec, 3);
    chk("ldi_data", {16'd0, ld_data}, 32'h00AA);

    // STI via null pointer, final write never acknowledged
    run_txn(MEM_STI, 16'h6000, 16'h5A5A, 0, -1, 0, ec, er);
    chk("sti_err_cycle", ec, 2 + TO + 1);
    chk("sti_err_flag", {31'd0, er}, 32'd1);
    chk("sti_ld_kept", {16'd0, ld_data}, 32'h00AA);
    chk("sti_no_write", {16'd0, memrd(16'h0000)}, 32'h0000);

    // Spurious ack in IDLE, then start pulsed while busy
    @(posedge clk); #1 force_ack = 1'b1;
    @(posedge clk); #1 force_ack = 1'b0;
    d0 = n_done;
    run_txn(MEM_LD, 16'h3010, 16'h0000, 2, 0, 1, ec, er);
    repeat (4) @(negedge clk);
    chk("busy_done_cycle", ec, 4);
    chk("busy_one_done", n_done - d0, 1);

    // Reset during pointer wait
    @(posedge clk); #1;
    start = 1'b1; op = MEM_LDI; ea = 16'h4000; st_data = 16'h0;
    resp_w[0] = -1; resp_w[1] = 0;
    plan(MEM_LDI, 16'h4000, 16'h0, -1, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_addr = '0; m_wd = '0; m_mdr = '0;
    #1;
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mid_ld", {16'd0, ld_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_txn(MEM_LD, 16'h0123, 16'h0000, 1, 0, 0, ec, er);
    chk("post_rst_done_cycle", ec, 3);
    chk("post_rst_ld", {16'd0, ld_data}, 32'h7777);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
